// File: rtl/hazard_forward_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_forward_scoreboard_if
// Decode-side bundle between the ID stage and the hazard/forwarding unit.
//   master : decode stage (drives flush, issue_*, src_*; reads fwd_sel/stall)
//   slave  : hazard_forward_scoreboard (reads issue/source info; drives
//            per-operand bypass selects and the decode stall)
// Signals
//   flush           squash all in-flight entries
//   issue_valid     decode slot holds a real instruction
//   issue_regwrite  decoded instruction writes a register
//   issue_is_load   decoded instruction is a load
//   issue_rd        decoded destination register
//   src_addr        source registers, operand i = [i*REG_AW +: REG_AW]
//   src_used        operand i actually read
//   fwd_sel         operand i bypass select, [i*SW +: SW]
//   stall           hold decode, bubble into stage 1
// ---------------------------------------------------------------------------
interface hazard_forward_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int NSRC   = 2
);
  localparam int SW = $clog2(DEPTH + 1);

  logic                   flush;
  logic                   issue_valid;
  logic                   issue_regwrite;
  logic                   issue_is_load;
  logic [REG_AW-1:0]      issue_rd;
  logic [NSRC*REG_AW-1:0] src_addr;
  logic [NSRC-1:0]        src_used;
  logic [NSRC*SW-1:0]     fwd_sel;
  logic                   stall;

  modport master (
    output flush, issue_valid, issue_regwrite, issue_is_load, issue_rd,
           src_addr, src_used,
    input  fwd_sel, stall
  );

  modport slave (
    input  flush, issue_valid, issue_regwrite, issue_is_load, issue_rd,
           src_addr, src_used,
    output fwd_sel, stall
  );
endinterface

// File: rtl/hazard_forward_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_forward_scoreboard
// Forwarding + load-use hazard unit beside the ID stage. A shift-register
// scoreboard records the destination of each of the DEPTH instructions past
// decode (stage 1 = EX ... stage DEPTH = WB). For each of NSRC source operands
// it selects the youngest in-flight producer's result bus, and it stalls
// decode when that producer is a load whose data is not yet available.
// Ports
//   clk           rising-edge clock
//   rst           async active-high reset, clears all entries
//   bus (slave)   decode bundle, see hazard_forward_scoreboard_if
//   stall_cycles  (only with HAZ_STALL_CNT_EN) saturating count of stall cycles
// Configuration
//   HAZ_STALL_CNT_EN  when defined, adds the stall_cycles output/counter.
// ---------------------------------------------------------------------------
module hazard_forward_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int NSRC       = 2,
  parameter int LOAD_READY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  hazard_forward_scoreboard_if.slave  bus
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);
  localparam int SW = $clog2(DEPTH + 1);

  // Scoreboard entries, index 1 = youngest (EX) ... DEPTH = oldest (WB)
  logic [DEPTH:1]    valid_r;
  logic [DEPTH:1]    regwrite_r;
  logic [DEPTH:1]    is_load_r;
  logic [REG_AW-1:0] rd_r [1:DEPTH];

  // Per-operand lookup results
  logic [NSRC-1:0]   found_s;
  logic [NSRC-1:0]   load_s;
  logic [NSRC-1:0]   early_s;
  logic [NSRC-1:0]   hazard_s;
  logic [SW-1:0]     kmin_s [NSRC];
  logic              stall_s;

  // Advance the scoreboard; flush squashes everything, stall injects a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= '0;
      regwrite_r <= '0;
      is_load_r  <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        rd_r[k] <= {REG_AW{1'b0}};
      end
    end else if (bus.flush) begin
      valid_r    <= '0;
      regwrite_r <= '0;
      is_load_r  <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        rd_r[k] <= {REG_AW{1'b0}};
      end
    end else begin
      valid_r[1]    <= bus.issue_valid & ~stall_s;
      regwrite_r[1] <= bus.issue_regwrite;
      is_load_r[1]  <= bus.issue_is_load;
      rd_r[1]       <= bus.issue_rd;
      for (int k = 2; k <= DEPTH; k++) begin
        valid_r[k]    <= valid_r[k-1];
        regwrite_r[k] <= regwrite_r[k-1];
        is_load_r[k]  <= is_load_r[k-1];
        rd_r[k]       <= rd_r[k-1];
      end
    end
  end

  // Find the youngest matching producer per operand; scanning oldest to
  // youngest lets the last hit (smallest k) win without a priority encoder
  always_comb begin
    found_s  = '0;
    load_s   = '0;
    early_s  = '0;
    hazard_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      kmin_s[i] = {SW{1'b0}};
      for (int k = DEPTH; k >= 1; k--) begin
        logic hit;
        hit = valid_r[k] & regwrite_r[k] &
              (rd_r[k] != {REG_AW{1'b0}}) &
              (rd_r[k] == bus.src_addr[i*REG_AW +: REG_AW]);
        found_s[i] = hit ? 1'b1         : found_s[i];
        kmin_s[i]  = hit ? SW'(k)       : kmin_s[i];
        load_s[i]  = hit ? is_load_r[k] : load_s[i];
        early_s[i] = hit ? (k < LOAD_READY) : early_s[i];
      end
      // A load still short of the data-carrying stage cannot be bypassed
      hazard_s[i] = bus.src_used[i] & found_s[i] & load_s[i] & early_s[i];
    end
  end

  assign stall_s   = |hazard_s;
  assign bus.stall = stall_s;

  // Bypass selects; zero whenever decode is held so the stalled operands
  // never pick up a half-ready value
  always_comb begin
    bus.fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (stall_s || !bus.src_used[i] || !found_s[i]) begin
        bus.fwd_sel[i*SW +: SW] = {SW{1'b0}};
      end else begin
        bus.fwd_sel[i*SW +: SW] = kmin_s[i];
      end
    end
  end

`ifdef HAZ_STALL_CNT_EN
  // Saturating stall-cycle counter; counts flush cycles that also stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'h0000_0000;
    end else if (stall_s && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'h0000_0001;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_scoreboard
// Directed bench for hazard_forward_scoreboard (REG_AW=5, DEPTH=3, NSRC=2,
// LOAD_READY=2). Expected stall/select values are queued as each step is
// driven and compared at the following falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_forward_scoreboard;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 3;
  localparam int NSRC   = 2;
  localparam int SW     = $clog2(DEPTH + 1);

  logic clk;
  logic rst;

  hazard_forward_scoreboard_if #(.REG_AW(REG_AW), .DEPTH(DEPTH), .NSRC(NSRC)) bus ();

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_forward_scoreboard #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .NSRC(NSRC), .LOAD_READY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef HAZ_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          st;
    logic [SW-1:0] s0;
    logic [SW-1:0] s1;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic fl, input logic iv, input logic rw, input logic ld,
                        input logic [4:0] rd, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [1:0] used);
    bus.flush          = fl;
    bus.issue_valid    = iv;
    bus.issue_regwrite = rw;
    bus.issue_is_load  = ld;
    bus.issue_rd       = rd;
    bus.src_addr       = {a1, a0};
    bus.src_used       = used;
  endtask

  // Pop the oldest expectation and compare against the live outputs
  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = q.pop_front();
      chk({e.tag, "_stall"}, {31'd0, bus.stall}, {31'd0, e.st});
      chk({e.tag, "_sel0"},  {30'd0, bus.fwd_sel[1:0]}, {30'd0, e.s0});
      chk({e.tag, "_sel1"},  {30'd0, bus.fwd_sel[3:2]}, {30'd0, e.s1});
    end
  endtask

  // One cycle: drive after the rising edge, check at the falling edge
  task automatic step(input string tag, input logic fl, input logic iv, input logic rw,
                      input logic ld, input logic [4:0] rd, input logic [4:0] a0,
                      input logic [4:0] a1, input logic [1:0] used,
                      input logic est, input logic [1:0] e0, input logic [1:0] e1);
    @(posedge clk);
    #1;
    set_in(fl, iv, rw, ld, rd, a0, a1, used);
    q.push_back('{tag, est, e0, e1});
    @(negedge clk);
    check_out();
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);

    // 1: reset with random inputs, then idle
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom));
      q.push_back('{"t1_rst", 1'b0, 2'd0, 2'd0});
      @(negedge clk);
      check_out();
    end
`ifdef HAZ_STALL_CNT_EN
    chk("t1_cnt_rst", stall_cycles, 32'd0);
`endif
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    end

    // 2: ALU producer walks EX -> MEM -> WB -> gone
    step("t2_issue", 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t2_ex",    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0, 2'd1, 2'd0);
    step("t2_mem",   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0, 2'd2, 2'd0);
    step("t2_wb",    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 2'b11, 1'b0, 2'd3, 2'd3);
    step("t2_gone",  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0, 2'd0, 2'd0);

    // 3: load-use stalls one cycle, bubble goes into EX, retry forwards from MEM
    step("t3_load",   1'b0, 1'b1, 1'b1, 1'b1, 5'd8,  5'd0,  5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t3_stall",  1'b0, 1'b1, 1'b1, 1'b0, 5'd10, 5'd0,  5'd8, 2'b10, 1'b1, 2'd0, 2'd0);
    step("t3_retry",  1'b0, 1'b1, 1'b1, 1'b0, 5'd10, 5'd0,  5'd8, 2'b10, 1'b0, 2'd0, 2'd2);
    step("t3_bubble", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd10, 5'd8, 2'b11, 1'b0, 2'd1, 2'd3);
    step("t3_flush",  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 2'b00, 1'b0, 2'd0, 2'd0);

    // 4: youngest producer wins; rd=0 / regwrite=0 / valid=0 never match
    step("t4_a",     1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t4_b",     1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t4_both1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 2'b11, 1'b0, 2'd1, 2'd1);
    step("t4_both2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 2'b11, 1'b0, 2'd2, 2'd2);
    step("t4_flush", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t4_z_a",   1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t4_z_b",   1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t4_rd0",   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, 2'd0, 2'd0);
    step("t4_nw_i",  1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t4_nowr",  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b01, 1'b0, 2'd0, 2'd0);
    step("t4_nv_i",  1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t4_noval", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 2'b01, 1'b0, 2'd0, 2'd0);

    // 5: flush at the same edge as a load-use stall clears the hazard
    step("t5_clr",   1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t5_load",  1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t5_flush", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 2'b01, 1'b1, 2'd0, 2'd0);
    step("t5_after", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 2'b01, 1'b0, 2'd0, 2'd0);

    // 6: fresh reset, four load-use pairs, then async reset during a stall
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
`ifdef HAZ_STALL_CNT_EN
    chk("t6_cnt_zero", stall_cycles, 32'd0);
`endif
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step("t6_load",  1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 5'd0,  5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
      step("t6_stall", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd11, 5'd0, 2'b01, 1'b1, 2'd0, 2'd0);
      step("t6_retry", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd11, 5'd0, 2'b01, 1'b0, 2'd2, 2'd0);
    end
    step("t6_idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
`ifdef HAZ_STALL_CNT_EN
    chk("t6_cnt_four", stall_cycles, 32'd4);
`endif
    step("t6_load2",  1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 5'd0,  5'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    step("t6_stall2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd12, 5'd0, 2'b01, 1'b1, 2'd0, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("t6_rst_sel",   {28'd0, bus.fwd_sel}, 32'd0);
`ifdef HAZ_STALL_CNT_EN
    chk("t6_rst_cnt", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_queue_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
